// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - registered program counter with redirect, trap and return-address stack
//
// Ports:
//   clk               in   clock, all state on rising edge
//   rst_n             in   asynchronous active-low reset
//   stall_i           in   hold PC, RAS and misalign flag this cycle
//   trap_i            in   force PC to TRAP_VECTOR (beats stall and redirect)
//   redirect_valid_i  in   apply redirect_mode_i this cycle
//   redirect_mode_i   in   00 branch, 01 jump-register, 10 call, 11 return
//   imm_i             in   signed byte offset for branch/call
//   target_i          in   absolute target for jump-register / empty-RAS return
//   pc_o              out  current PC (register)
//   pc_next_seq_o     out  pc_o + INSTR_BYTES (link value)
//   misalign_o        out  one-cycle pulse: last redirect target misaligned
//   ras_empty_o       out  RAS holds no entries
//   ras_full_o        out  RAS holds RAS_DEPTH entries
//   ras_overflow_o    out  sticky: a call pushed while the RAS was full

module pc_unit #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int unsigned     INSTR_BYTES  = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            trap_i,
  input  logic            redirect_valid_i,
  input  logic [1:0]      redirect_mode_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] target_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_next_seq_o,
  output logic            misalign_o,
  output logic            ras_empty_o,
  output logic            ras_full_o,
  output logic            ras_overflow_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [XLEN-1:0]  ONE        = XLEN'(1);
  localparam logic [XLEN-1:0]  STEP       = XLEN'(INSTR_BYTES);
  localparam logic [XLEN-1:0]  ALIGN_MASK = STEP - ONE;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    MODE_BRANCH = 2'b00,
    MODE_JR     = 2'b01,
    MODE_CALL   = 2'b10,
    MODE_RET    = 2'b11
  } mode_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             misalign_q, misalign_d;
  logic             overflow_q, overflow_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;      // next free slot; top entry is ptr_q-1
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  ras_q [RAS_DEPTH];

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] rel_target;
  logic [XLEN-1:0] jr_target;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] redirect_target;
  logic            ras_empty;
  logic            ras_full;
  logic            target_misaligned;
  logic            push_en;
  mode_e           mode;

  assign mode       = mode_e'(redirect_mode_i);
  assign pc_seq     = pc_q + STEP;
  assign rel_target = pc_q + imm_i;   // two's complement add, wraps silently
  assign jr_target  = target_i & ~ONE;
  assign ras_top    = ras_q[ptr_q - PTR_ONE];
  assign ras_empty  = (cnt_q == '0);
  assign ras_full   = (cnt_q == DEPTH_C);

  always_comb begin
    redirect_target = rel_target;
    unique case (mode)
      MODE_BRANCH: redirect_target = rel_target;
      MODE_JR:     redirect_target = jr_target;
      MODE_CALL:   redirect_target = rel_target;
      MODE_RET:    redirect_target = ras_empty ? jr_target : ras_top;
      default:     redirect_target = rel_target;
    endcase
  end

  // Alignment is checked on the final target, so jump-register and empty-RAS
  // returns are judged after bit0 has already been cleared.
  assign target_misaligned = |(redirect_target & ALIGN_MASK);

  // ---------------------------------------------------------------------------
  // Next-state selection: trap > stall > redirect > sequential
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d       = pc_q;
    misalign_d = misalign_q;
    overflow_d = overflow_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    push_en    = 1'b0;

    if (trap_i) begin
      pc_d       = TRAP_VECTOR;
      misalign_d = 1'b0;
    end else if (stall_i) begin
      // everything holds; a redirect offered under stall is dropped
      pc_d = pc_q;
    end else if (redirect_valid_i) begin
      pc_d       = target_misaligned ? TRAP_VECTOR : redirect_target;
      misalign_d = target_misaligned;

      // RAS side effects happen even when the target turns out misaligned
      if (mode == MODE_CALL) begin
        push_en = 1'b1;
        ptr_d   = ptr_q + PTR_ONE;
        if (ras_full) begin
          // oldest entry sits at ptr_q when full, so the write replaces it
          overflow_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else if (mode == MODE_RET && !ras_empty) begin
        ptr_d = ptr_q - PTR_ONE;
        cnt_d = cnt_q - CNT_ONE;
      end
    end else begin
      pc_d       = pc_seq;
      misalign_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
      overflow_q <= 1'b0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      overflow_q <= overflow_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // Entry storage needs no reset: clearing the count makes old contents
  // unreachable.
  always_ff @(posedge clk) begin
    if (push_en) begin
      ras_q[ptr_q] <= pc_seq;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pc_o           = pc_q;
  assign pc_next_seq_o  = pc_seq;
  assign misalign_o     = misalign_q;
  assign ras_empty_o    = ras_empty;
  assign ras_full_o     = ras_full;
  assign ras_overflow_o = overflow_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit

module tb_pc_unit;

  localparam logic [31:0] TRAP = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        trap_i;
  logic        redirect_valid_i;
  logic [1:0]  redirect_mode_i;
  logic [31:0] imm_i;
  logic [31:0] target_i;
  logic [31:0] pc_o;
  logic [31:0] pc_next_seq_o;
  logic        misalign_o;
  logic        ras_empty_o;
  logic        ras_full_o;
  logic        ras_overflow_o;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  pc_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall_i),
    .trap_i           (trap_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_mode_i  (redirect_mode_i),
    .imm_i            (imm_i),
    .target_i         (target_i),
    .pc_o             (pc_o),
    .pc_next_seq_o    (pc_next_seq_o),
    .misalign_o       (misalign_o),
    .ras_empty_o      (ras_empty_o),
    .ras_full_o       (ras_full_o),
    .ras_overflow_o   (ras_overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: PC as a number, RAS as a bounded list of link values
  logic [31:0] m_pc  = 32'h0;
  logic        m_mis = 1'b0;
  logic        m_ovf = 1'b0;
  logic [31:0] m_ras[$];

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] tgt;
    if (!rst_n) begin
      m_pc  = 32'h0;
      m_mis = 1'b0;
      m_ovf = 1'b0;
      m_ras.delete();
    end else if (trap_i) begin
      m_pc  = TRAP;
      m_mis = 1'b0;
    end else if (stall_i) begin
      m_pc = m_pc;
    end else if (redirect_valid_i) begin
      case (redirect_mode_i)
        2'b00: tgt = m_pc + imm_i;
        2'b01: tgt = target_i & 32'hFFFF_FFFE;
        2'b10: begin
          tgt = m_pc + imm_i;
          if (m_ras.size() == 4) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
          m_ras.push_back(m_pc + 32'd4);
        end
        default: begin
          if (m_ras.size() > 0) tgt = m_ras.pop_back();
          else                  tgt = target_i & 32'hFFFF_FFFE;
        end
      endcase
      if (tgt % 4 != 0) begin
        m_pc  = TRAP;
        m_mis = 1'b1;
      end else begin
        m_pc  = tgt;
        m_mis = 1'b0;
      end
    end else begin
      m_pc  = m_pc + 32'd4;
      m_mis = 1'b0;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model pc_o",           pc_o,                   m_pc);
      cmp("model pc_next_seq_o",  pc_next_seq_o,          m_pc + 32'd4);
      cmp("model misalign_o",     {31'b0, misalign_o},    {31'b0, m_mis});
      cmp("model ras_empty_o",    {31'b0, ras_empty_o},   {31'b0, m_ras.size() == 0});
      cmp("model ras_full_o",     {31'b0, ras_full_o},    {31'b0, m_ras.size() == 4});
      cmp("model ras_overflow_o", {31'b0, ras_overflow_o}, {31'b0, m_ovf});
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    trap_i           = 1'b0;
    stall_i          = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_mode_i  = 2'b00;
    imm_i            = 32'h0;
    target_i         = 32'h0;
  endtask

  task automatic redirect(input logic [1:0] mode, input logic [31:0] imm, input logic [31:0] tgt);
    redirect_valid_i = 1'b1;
    redirect_mode_i  = mode;
    imm_i            = imm;
    target_i         = tgt;
    step();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // reset state and free-running sequence
    cmp("reset pc_o", pc_o, 32'h0);
    cmp("reset ras_empty_o", {31'b0, ras_empty_o}, 32'h1);
    cmp("reset ras_overflow_o", {31'b0, ras_overflow_o}, 32'h0);
    rst_n = 1'b1;
    step(); cmp("seq 1", pc_o, 32'h4);
    step(); cmp("seq 2", pc_o, 32'h8);
    step(); cmp("seq 3", pc_o, 32'hC);
    cmp("seq ras_empty_o", {31'b0, ras_empty_o}, 32'h1);
    repeat (5) step();
    cmp("reach 0x20", pc_o, 32'h20);

    // branches, including a misaligned target
    redirect(2'b00, 32'hFFFF_FFF0, 32'h0);
    cmp("branch back", pc_o, 32'h10);
    redirect(2'b00, 32'h6, 32'h0);
    cmp("misaligned branch pc", pc_o, TRAP);
    cmp("misaligned branch flag", {31'b0, misalign_o}, 32'h1);
    step();
    cmp("misalign pulse ends", {31'b0, misalign_o}, 32'h0);
    cmp("after trap vector", pc_o, 32'h104);

    // jump-register clears bit0, then stall drops a branch
    redirect(2'b01, 32'h0, 32'h41);
    cmp("jr bit0 cleared", pc_o, 32'h40);
    stall_i = 1'b1;
    redirect(2'b00, 32'h80, 32'h0);
    stall_i = 1'b1;
    redirect(2'b00, 32'h80, 32'h0);
    cmp("stall holds", pc_o, 32'h40);
    step();
    cmp("stall branch dropped", pc_o, 32'h44);
    stall_i = 1'b1;
    trap_i  = 1'b1;
    step();
    clear_inputs();
    cmp("trap beats stall", pc_o, TRAP);

    // nested calls and returns
    redirect(2'b01, 32'h0, 32'h10);
    redirect(2'b10, 32'h20, 32'h0);
    cmp("call 1", pc_o, 32'h30);
    redirect(2'b10, 32'h20, 32'h0);
    redirect(2'b10, 32'h100, 32'h0);
    cmp("call 3", pc_o, 32'h150);
    redirect(2'b11, 32'h0, 32'h0);
    cmp("return 1", pc_o, 32'h54);
    redirect(2'b11, 32'h0, 32'h0);
    cmp("return 2", pc_o, 32'h34);
    redirect(2'b11, 32'h0, 32'h0);
    cmp("return 3", pc_o, 32'h14);
    cmp("ras empty after returns", {31'b0, ras_empty_o}, 32'h1);
    redirect(2'b11, 32'h0, 32'h201);
    cmp("empty return fallback", pc_o, 32'h200);

    // overflow: five calls into a four-deep stack
    for (int i = 0; i < 5; i++) redirect(2'b10, 32'h10, 32'h0);
    cmp("ras_full_o", {31'b0, ras_full_o}, 32'h1);
    cmp("ras_overflow_o set", {31'b0, ras_overflow_o}, 32'h1);
    redirect(2'b11, 32'h0, 32'h0); cmp("ovf return 1", pc_o, 32'h244);
    redirect(2'b11, 32'h0, 32'h0); cmp("ovf return 2", pc_o, 32'h234);
    redirect(2'b11, 32'h0, 32'h0); cmp("ovf return 3", pc_o, 32'h224);
    redirect(2'b11, 32'h0, 32'h0); cmp("ovf return 4", pc_o, 32'h214);
    cmp("overflow sticky", {31'b0, ras_overflow_o}, 32'h1);

    // misaligned call still pushes its link
    redirect(2'b10, 32'h2, 32'h0);
    cmp("misaligned call pc", pc_o, TRAP);
    redirect(2'b11, 32'h0, 32'h0);
    cmp("misaligned call link", pc_o, 32'h218);

    // wrap-around, then reset with live RAS entries
    redirect(2'b01, 32'h0, 32'hFFFF_FFFC);
    step();
    cmp("pc wraps", pc_o, 32'h0);
    redirect(2'b10, 32'h8, 32'h0);
    redirect(2'b10, 32'h8, 32'h0);
    cmp("two calls pc", pc_o, 32'h10);
    #2 rst_n = 1'b0;
    #1;
    cmp("async reset pc_o", pc_o, 32'h0);
    cmp("async reset ras_empty_o", {31'b0, ras_empty_o}, 32'h1);
    cmp("async reset ras_overflow_o", {31'b0, ras_overflow_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    cmp("post reset seq", pc_o, 32'h4);
    redirect(2'b11, 32'h0, 32'h301);
    cmp("post reset return uses fallback", pc_o, 32'h300);
    step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
